// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings and types for the branch prediction unit: counter states,
// the branch opcode and the layout of a prediction-tracking slot.
package branch_predict_unit_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam ctr_e       CTR_RESET  = WNT;

    // One in-flight prediction, carried from fetch to execute.
    typedef struct packed {
        logic        v;
        logic        pred_taken;
        logic [31:0] pred_target;
    } track_t;

endpackage

// File: rtl/branch_predict_unit_btb_array.sv
// Direct-mapped BTB storage: asynchronous lookup port, synchronous
// allocate/update port, and the 2-bit saturating counter arithmetic.
module btb_array
    import branch_predict_unit_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX     = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rd_pc_i,
    output logic        rd_hit_o,
    output ctr_e        rd_ctr_o,
    output logic [31:0] rd_target_o,
    input  logic        wr_en_i,
    input  logic        wr_taken_i,
    input  logic [31:0] wr_pc_i,
    input  logic [31:0] wr_target_i
);

    localparam int TAG_W = 30 - IDX;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    ctr_e             ctr_q    [ENTRIES];

    logic [IDX-1:0]   rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             wr_hit;
    ctr_e             wr_ctr_next;
    logic             unused_pc_bits;

    assign rd_idx = rd_pc_i[IDX+1:2];
    assign rd_tag = rd_pc_i[31:IDX+2];
    assign wr_idx = wr_pc_i[IDX+1:2];
    assign wr_tag = wr_pc_i[31:IDX+2];
    assign unused_pc_bits = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

    // Lookup sees the pre-update contents when it shares an index with a write.
    assign rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_ctr_o    = ctr_q[rd_idx];
    assign rd_target_o = target_q[rd_idx];

    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        wr_ctr_next = ctr_q[wr_idx];
        unique case (ctr_q[wr_idx])
            SNT: wr_ctr_next = wr_taken_i ? WNT : SNT;
            WNT: wr_ctr_next = wr_taken_i ? WT  : SNT;
            WT:  wr_ctr_next = wr_taken_i ? ST  : WNT;
            ST:  wr_ctr_next = wr_taken_i ? ST  : WT;
            default: wr_ctr_next = CTR_RESET;
        endcase
    end

    // NOTE: the array is reset explicitly because a reset must leave every entry a guaranteed miss;
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (wr_en_i) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= wr_ctr_next;
                if (wr_taken_i) begin
                    target_q[wr_idx] <= wr_target_i;
                end
            end else if (wr_taken_i) begin
                valid_q[wr_idx]  <= 1'b1;
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= wr_target_i;
                ctr_q[wr_idx]    <= WT;
            end
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction/resolution unit beside fetch: BTB lookup at F, F->D->E
// prediction tracking, misprediction detection in E. BPU_PERF_CNT_EN adds counters.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    input  logic [31:0] InstrF,
    input  logic        LoadD,
    input  logic        BranchE,
    input  logic        Branch_resultE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] predicted_address,
    output logic        sel,
    output logic        flag,
    output logic [31:0] PCback
`ifdef BPU_PERF_CNT_EN
    ,
    output logic [31:0] BrCountE,
    output logic [31:0] MispCountE
`endif
);

    localparam int IDX = $clog2(BTB_ENTRIES);

    logic        btb_hit;
    ctr_e        btb_ctr;
    logic [31:0] btb_target;
    logic        lookup_hit;
    logic        resolve;
    logic        unused_instr_bits;

    track_t fd_q, fd_d;
    track_t de_q, de_d;

    assign unused_instr_bits = ^InstrF[31:7];

    btb_array #(
        .ENTRIES (BTB_ENTRIES),
        .IDX     (IDX)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .rd_pc_i     (PCF),
        .rd_hit_o    (btb_hit),
        .rd_ctr_o    (btb_ctr),
        .rd_target_o (btb_target),
        .wr_en_i     (resolve),
        .wr_taken_i  (Branch_resultE),
        .wr_pc_i     (PCE),
        .wr_target_i (PCTargetE)
    );

    assign lookup_hit        = btb_hit && (InstrF[6:0] == OPC_BRANCH);
    assign sel               = lookup_hit && btb_ctr[1];
    assign predicted_address = sel ? btb_target : '0;

    // A BranchE arriving on a bubble (DE invalid) is ignored entirely.
    assign resolve = BranchE && de_q.v;

    always_comb begin
        flag   = 1'b0;
        PCback = '0;
        if (resolve) begin
            if (de_q.pred_taken && !Branch_resultE) begin
                flag   = 1'b1;
                PCback = PCE + 32'd4;
            end else if (Branch_resultE &&
                         (!de_q.pred_taken || (de_q.pred_target != PCTargetE))) begin
                flag   = 1'b1;
                PCback = PCTargetE;
            end
        end
    end

    // A flush outranks a load-use stall: both slots hold younger, discarded work.
    always_comb begin
        fd_d = '{v: 1'b1, pred_taken: sel, pred_target: predicted_address};
        de_d = fd_q;
        if (flag) begin
            fd_d = '0;
            de_d = '0;
        end else if (LoadD) begin
            fd_d = fd_q;
            de_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fd_q <= '0;
            de_q <= '0;
        end else begin
            fd_q <= fd_d;
            de_q <= de_d;
        end
    end

`ifdef BPU_PERF_CNT_EN
    logic [31:0] br_cnt_q, misp_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt_q   <= '0;
            misp_cnt_q <= '0;
        end else begin
            if (resolve && (br_cnt_q != 32'hFFFF_FFFF)) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (flag && (misp_cnt_q != 32'hFFFF_FFFF)) begin
                misp_cnt_q <= misp_cnt_q + 32'd1;
            end
        end
    end

    assign BrCountE   = br_cnt_q;
    assign MispCountE = misp_cnt_q;
`endif

endmodule
